// File: rtl/spu_pkg.sv
// Shared definitions for the SPU event counter.
// Contents: config register addresses, CTRL/FILTER bit positions,
// privilege encodings of e_info, and the config-port FSM state type.
package spu_pkg;

   localparam logic [3:0] ADDR_CTRL     = 4'd0;
   localparam logic [3:0] ADDR_FILTER   = 4'd1;
   localparam logic [3:0] ADDR_STATUS   = 4'd2;
   localparam logic [3:0] ADDR_CNT_BASE = 4'd4;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_FREEZE_BIT = 1;
   localparam int CTRL_CLR_BIT    = 2;
   localparam int CTRL_IRQ_LSB    = 8;

   localparam int FLT_MASK_LSB    = 0;
   localparam int FLT_ASID_EN_BIT = 3;
   localparam int FLT_ASID_LSB    = 16;

   localparam logic [1:0] PRIV_M = 2'b01;
   localparam logic [1:0] PRIV_S = 2'b10;
   localparam logic [1:0] PRIV_U = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } cfg_state_e;

endpackage

// File: rtl/spu_cnt_slice.sv
// One event counter.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          clear to zero (highest priority)
//   load_i         load load_val_i (beats increment)
//   inc_i          count by one, modulo 2^CNT_WIDTH
//   cnt_o          current count
//   wrap_o         combinational pulse: this edge takes the count from all-ones to zero
module spu_cnt_slice #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 load_i,
   input  logic [CNT_WIDTH-1:0] load_val_i,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 wrap_o
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (load_i) begin
         cnt_o <= load_val_i;
      end else if (inc_i) begin
         cnt_o <= cnt_o + ONE;
      end
   end

   // A masked increment (clear or load in the same cycle) never reports a wrap.
   assign wrap_o = inc_i & ~clr_i & ~load_i & (&cnt_o);

endmodule

// File: rtl/spu_event_counter.sv
// SPU event counter: registers the event stream from the event unit, filters
// it by source, privilege and ASID, and counts each event line.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   e_id_i              event pulses, one bit per line
//   e_info_i            {priv[1:0], asid}
//   s_id_i              source id of the event word
//   cfg_*               valid/ready config request, rvalid/rready response
//   ovf_irq_o           per-line level IRQ = sticky overflow & irq enable
//
// Config FSM
//   state | meaning
//   IDLE  | ready for a request; write or read capture happens on accept
//   RESP  | response presented, rdata/err held until cfg_rready_i
module spu_event_counter
   import spu_pkg::*;
#(
   parameter int NUM_EVENTS = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int ASID_WIDTH = 16,
   parameter bit SRC_ID     = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_EVENTS-1:0] e_id_i,
   input  logic [ASID_WIDTH+1:0] e_info_i,
   input  logic                  s_id_i,
   input  logic                  cfg_valid_i,
   output logic                  cfg_ready_o,
   input  logic                  cfg_we_i,
   input  logic [3:0]            cfg_addr_i,
   input  logic [31:0]           cfg_wdata_i,
   output logic                  cfg_rvalid_o,
   input  logic                  cfg_rready_i,
   output logic [31:0]           cfg_rdata_o,
   output logic                  cfg_err_o,
   output logic [NUM_EVENTS-1:0] ovf_irq_o
);

   logic [NUM_EVENTS-1:0] e_id_q;
   logic [1:0]            priv_q;
   logic [ASID_WIDTH-1:0] asid_q;
   logic                  s_id_q;

   logic                  ctrl_en_q, ctrl_frz_q;
   logic [NUM_EVENTS-1:0] irq_en_q;
   logic [2:0]            flt_mask_q;
   logic                  flt_asid_en_q;
   logic [ASID_WIDTH-1:0] flt_asid_q;
   logic [NUM_EVENTS-1:0] status_q;

   cfg_state_e            state_q, state_d;
   logic                  cfg_accept, cfg_wr, clear_all;
   logic                  sel_ctrl, sel_flt, sel_stat, addr_ok;
   logic [NUM_EVENTS-1:0] sel_cnt, wrap, w1c;
   logic [31:0]           rdata_d;
   logic                  priv_ok, asid_ok, count_ok;
   logic [CNT_WIDTH-1:0]  cnt [NUM_EVENTS];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         e_id_q <= '0;
         priv_q <= '0;
         asid_q <= '0;
         s_id_q <= 1'b0;
      end else begin
         e_id_q <= e_id_i;
         priv_q <= e_info_i[ASID_WIDTH +: 2];
         asid_q <= e_info_i[ASID_WIDTH-1:0];
         s_id_q <= s_id_i;
      end
   end

   always_comb begin
      case (priv_q)
         PRIV_M:  priv_ok = flt_mask_q[0];
         PRIV_S:  priv_ok = flt_mask_q[1];
         PRIV_U:  priv_ok = flt_mask_q[2];
         default: priv_ok = 1'b0;
      endcase
   end

   assign asid_ok  = ~flt_asid_en_q | (asid_q == flt_asid_q);
   assign count_ok = ctrl_en_q & ~ctrl_frz_q & (s_id_q == SRC_ID) & priv_ok & asid_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cfg_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready_o = 1'b1;
            if (cfg_valid_i) state_d = RESP;
         end
         RESP: begin
            if (cfg_rready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cfg_rvalid_o = (state_q == RESP);
   assign cfg_accept   = cfg_valid_i & cfg_ready_o;
   assign cfg_wr       = cfg_accept & cfg_we_i;
   assign clear_all    = cfg_wr & sel_ctrl & cfg_wdata_i[CTRL_CLR_BIT];

   always_comb begin
      sel_ctrl = (cfg_addr_i == ADDR_CTRL);
      sel_flt  = (cfg_addr_i == ADDR_FILTER);
      sel_stat = (cfg_addr_i == ADDR_STATUS);
      sel_cnt  = '0;
      rdata_d  = '0;
      for (int k = 0; k < NUM_EVENTS; k++) begin
         if (cfg_addr_i == ADDR_CNT_BASE + 4'(k)) sel_cnt[k] = 1'b1;
      end
      addr_ok = sel_ctrl | sel_flt | sel_stat | (|sel_cnt);
      if (sel_ctrl) begin
         rdata_d[CTRL_EN_BIT]                   = ctrl_en_q;
         rdata_d[CTRL_FREEZE_BIT]               = ctrl_frz_q;
         rdata_d[CTRL_IRQ_LSB +: NUM_EVENTS]    = irq_en_q;
      end
      if (sel_flt) begin
         rdata_d[FLT_MASK_LSB +: 3]             = flt_mask_q;
         rdata_d[FLT_ASID_EN_BIT]               = flt_asid_en_q;
         rdata_d[FLT_ASID_LSB +: ASID_WIDTH]    = flt_asid_q;
      end
      if (sel_stat) rdata_d[NUM_EVENTS-1:0] = status_q;
      for (int k = 0; k < NUM_EVENTS; k++) begin
         if (sel_cnt[k]) rdata_d = 32'(cnt[k]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_en_q     <= 1'b0;
         ctrl_frz_q    <= 1'b0;
         irq_en_q      <= '0;
         flt_mask_q    <= 3'b111;
         flt_asid_en_q <= 1'b0;
         flt_asid_q    <= '0;
      end else if (cfg_wr) begin
         if (sel_ctrl) begin
            ctrl_en_q  <= cfg_wdata_i[CTRL_EN_BIT];
            ctrl_frz_q <= cfg_wdata_i[CTRL_FREEZE_BIT];
            irq_en_q   <= cfg_wdata_i[CTRL_IRQ_LSB +: NUM_EVENTS];
         end
         if (sel_flt) begin
            flt_mask_q    <= cfg_wdata_i[FLT_MASK_LSB +: 3];
            flt_asid_en_q <= cfg_wdata_i[FLT_ASID_EN_BIT];
            flt_asid_q    <= cfg_wdata_i[FLT_ASID_LSB +: ASID_WIDTH];
         end
      end
   end

   // A wrap on the same edge as a W1C of that bit keeps the bit set.
   assign w1c = (cfg_wr & sel_stat) ? cfg_wdata_i[NUM_EVENTS-1:0] : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) status_q <= '0;
      else       status_q <= (status_q & ~w1c) | wrap;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_rdata_o <= '0;
         cfg_err_o   <= 1'b0;
      end else if (cfg_accept) begin
         cfg_rdata_o <= cfg_we_i ? 32'd0 : (addr_ok ? rdata_d : 32'd0);
         cfg_err_o   <= ~addr_ok;
      end
   end

   assign ovf_irq_o = status_q & irq_en_q;

   for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_slice
      spu_cnt_slice #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_slice (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clr_i      (clear_all),
         .load_i     (cfg_wr & sel_cnt[k]),
         .load_val_i (cfg_wdata_i[CNT_WIDTH-1:0]),
         .inc_i      (e_id_q[k] & count_ok),
         .cnt_o      (cnt[k]),
         .wrap_o     (wrap[k])
      );
   end

endmodule

// File: tb/tb_spu_event_counter.sv
module tb_spu_event_counter;
   import spu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  e_id;
   logic [17:0] e_info;
   logic        s_id;
   logic        cfg_valid, cfg_ready, cfg_we, cfg_rvalid, cfg_rready, cfg_err;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata;
   logic [3:0]  ovf_irq;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   spu_event_counter dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .e_id_i       (e_id),
      .e_info_i     (e_info),
      .s_id_i       (s_id),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .cfg_we_i     (cfg_we),
      .cfg_addr_i   (cfg_addr),
      .cfg_wdata_i  (cfg_wdata),
      .cfg_rvalid_o (cfg_rvalid),
      .cfg_rready_i (cfg_rready),
      .cfg_rdata_o  (cfg_rdata),
      .cfg_err_o    (cfg_err),
      .ovf_irq_o    (ovf_irq)
   );

   typedef struct {
      logic [2:0]  mask;
      logic        asid_en;
      logic [15:0] f_asid;
      logic [3:0]  ev;
      logic [1:0]  priv;
      logic [15:0] asid;
      logic        sid;
      logic [3:0]  exp;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for handshake", name);
   endtask

   task automatic cfg_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
      int n;
      cfg_valid = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
      n = 0;
      while (!cfg_ready && n < 20) begin tick(); n++; end
      if (!cfg_ready) timeout("cfg_ready");
      tick();
      cfg_valid = 1'b0; cfg_we = 1'b0;
      n = 0;
      while (!cfg_rvalid && n < 20) begin tick(); n++; end
      if (!cfg_rvalid) timeout("cfg_rvalid");
      rd = cfg_rdata; err = cfg_err;
      cfg_rready = 1'b1;
      tick();
      cfg_rready = 1'b0;
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
      logic [31:0] rd; logic err;
      cfg_xfer(1'b1, addr, wd, rd, err);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] rd; logic err;
      cfg_xfer(1'b0, addr, 32'h0, rd, err);
      chk(name, rd, exp);
      chk({name, "_err"}, 32'(err), 32'h0);
   endtask

   task automatic ev(input logic [3:0] e, input logic [1:0] p, input logic [15:0] a,
                     input logic sid, input int n);
      e_id = e; e_info = {p, a}; s_id = sid;
      repeat (n) tick();
      e_id = '0; s_id = 1'b0;
   endtask

   task automatic settle();
      repeat (2) tick();
   endtask

   // Event registered on one edge, cfg write accepted on the next: the
   // increment and the write land on the same counter edge.
   task automatic collide(input logic [3:0] e, input logic [3:0] addr, input logic [31:0] wd);
      e_id = e; e_info = {PRIV_M, 16'h0}; s_id = 1'b0;
      tick();
      e_id = '0;
      cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = wd;
      tick();
      cfg_valid = 1'b0; cfg_we = 1'b0; cfg_rready = 1'b1;
      tick();
      cfg_rready = 1'b0;
      settle();
   endtask

   function automatic logic model_ok(input logic en, input logic frz, input logic [2:0] mask,
                                     input logic asid_en, input logic [15:0] f_asid,
                                     input logic [1:0] p, input logic [15:0] a, input logic sid);
      int pi;
      pi = int'(p);
      if (!en || frz || sid != 1'b0 || pi == 0) return 1'b0;
      if (!mask[pi-1]) return 1'b0;
      if (asid_en && a != f_asid) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      logic [31:0] m_cnt [4];
      logic [3:0]  m_stat;

      vecs[0] = '{3'b111, 1'b0, 16'h12, 4'b1111, PRIV_M, 16'h0000, 1'b0, 4'b1111};
      vecs[1] = '{3'b001, 1'b0, 16'h12, 4'b0011, PRIV_S, 16'h0000, 1'b0, 4'b0000};
      vecs[2] = '{3'b010, 1'b0, 16'h12, 4'b0110, PRIV_S, 16'h0000, 1'b0, 4'b0110};
      vecs[3] = '{3'b111, 1'b0, 16'h12, 4'b1111, 2'b00,  16'h0000, 1'b0, 4'b0000};
      vecs[4] = '{3'b100, 1'b1, 16'h12, 4'b1001, PRIV_U, 16'h0012, 1'b0, 4'b1001};
      vecs[5] = '{3'b100, 1'b1, 16'h12, 4'b1001, PRIV_U, 16'h0013, 1'b0, 4'b0000};
      vecs[6] = '{3'b111, 1'b0, 16'h12, 4'b0101, PRIV_U, 16'h0055, 1'b1, 4'b0000};
      vecs[7] = '{3'b011, 1'b1, 16'h12, 4'b1010, PRIV_M, 16'h0012, 1'b0, 4'b1010};

      rst_i = 1'b1; e_id = '0; e_info = '0; s_id = 1'b0;
      cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_rready = 1'b0;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      chk("rst_ready", 32'(cfg_ready), 32'h1);
      chk("rst_rvalid", 32'(cfg_rvalid), 32'h0);
      chk("rst_rdata", cfg_rdata, 32'h0);
      chk("rst_err", 32'(cfg_err), 32'h0);
      chk("rst_irq", 32'(ovf_irq), 32'h0);
      rd_chk("rst_ctrl", ADDR_CTRL, 32'h0);
      rd_chk("rst_filter", ADDR_FILTER, 32'h7);
      rd_chk("rst_status", ADDR_STATUS, 32'h0);
      for (int k = 0; k < 4; k++) rd_chk($sformatf("rst_cnt%0d", k), ADDR_CNT_BASE + 4'(k), 32'h0);

      // basic counting
      wr(ADDR_CTRL, 32'h1);
      ev(4'b0101, PRIV_M, 16'h0, 1'b0, 3);
      settle();
      rd_chk("basic_c0", 4'd4, 32'd3);
      rd_chk("basic_c1", 4'd5, 32'd0);
      rd_chk("basic_c2", 4'd6, 32'd3);
      rd_chk("basic_c3", 4'd7, 32'd0);

      // U-only with ASID match
      wr(ADDR_FILTER, (32'h12 << 16) | 32'h8 | 32'h4);
      rd_chk("filter_rb", ADDR_FILTER, 32'h0012_000C);
      wr(ADDR_CTRL, 32'h5);
      ev(4'b0010, PRIV_U, 16'h12, 1'b0, 5);
      ev(4'b0010, PRIV_U, 16'h13, 1'b0, 2);
      ev(4'b0010, PRIV_M, 16'h12, 1'b0, 2);
      settle();
      rd_chk("asid_c1", 4'd5, 32'd5);
      ev(4'b0010, PRIV_U, 16'h12, 1'b1, 1);
      settle();
      rd_chk("sid_c1", 4'd5, 32'd5);

      // table of filter cases
      for (int i = 0; i < 8; i++) begin
         wr(ADDR_FILTER, (32'(vecs[i].f_asid) << 16) | (32'(vecs[i].asid_en) << 3) | 32'(vecs[i].mask));
         wr(ADDR_CTRL, 32'h5);
         ev(vecs[i].ev, vecs[i].priv, vecs[i].asid, vecs[i].sid, 1);
         settle();
         for (int k = 0; k < 4; k++)
            rd_chk($sformatf("vec%0d_c%0d", i, k), ADDR_CNT_BASE + 4'(k), 32'(vecs[i].exp[k]));
      end

      // randomized against model
      for (int it = 0; it < 20; it++) begin
         logic en, frz, aen;
         logic [2:0] mask;
         logic [15:0] fa;
         logic [3:0] irq_en;
         en = ($urandom_range(0, 4) != 0);
         frz = ($urandom_range(0, 3) == 0);
         aen = $urandom_range(0, 1);
         mask = 3'($urandom);
         fa = ($urandom_range(0, 1) != 0) ? 16'h12 : 16'h34;
         irq_en = 4'($urandom);
         wr(ADDR_CTRL, 32'h0);
         for (int k = 0; k < 4; k++) begin
            m_cnt[k] = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFFF - $urandom_range(0, 5)) : $urandom;
            wr(ADDR_CNT_BASE + 4'(k), m_cnt[k]);
         end
         wr(ADDR_STATUS, 32'hF);
         m_stat = '0;
         wr(ADDR_FILTER, (32'(fa) << 16) | (32'(aen) << 3) | 32'(mask));
         wr(ADDR_CTRL, (32'(irq_en) << 8) | (32'(frz) << 1) | 32'(en));
         for (int c = 0; c < 12; c++) begin
            logic [3:0]  e;
            logic [1:0]  p;
            logic [15:0] a;
            logic        sid;
            e = 4'($urandom);
            p = 2'($urandom);
            a = ($urandom_range(0, 1) != 0) ? 16'h12 : 16'h34;
            sid = ($urandom_range(0, 3) == 0);
            e_id = e; e_info = {p, a}; s_id = sid;
            if (model_ok(en, frz, mask, aen, fa, p, a, sid)) begin
               for (int k = 0; k < 4; k++) begin
                  if (e[k]) begin
                     if (m_cnt[k] == 32'hFFFF_FFFF) m_stat[k] = 1'b1;
                     m_cnt[k] = m_cnt[k] + 32'd1;
                  end
               end
            end
            tick();
         end
         e_id = '0; s_id = 1'b0;
         settle();
         for (int k = 0; k < 4; k++)
            rd_chk($sformatf("rnd%0d_c%0d", it, k), ADDR_CNT_BASE + 4'(k), m_cnt[k]);
         rd_chk($sformatf("rnd%0d_stat", it), ADDR_STATUS, 32'(m_stat));
         chk($sformatf("rnd%0d_irq", it), 32'(ovf_irq), 32'(m_stat & irq_en));
      end

      // overflow and irq
      wr(ADDR_FILTER, 32'h7);
      wr(ADDR_STATUS, 32'hF);
      wr(ADDR_CNT_BASE + 4'd3, 32'hFFFF_FFFE);
      wr(ADDR_CTRL, 32'h801);
      ev(4'b1000, PRIV_M, 16'h0, 1'b0, 2);
      settle();
      rd_chk("ovf_c3", 4'd7, 32'h0);
      rd_chk("ovf_stat", ADDR_STATUS, 32'h8);
      chk("ovf_irq", 32'(ovf_irq), 32'h8);
      wr(ADDR_STATUS, 32'h8);
      chk("ovf_irq_cleared", 32'(ovf_irq), 32'h0);
      rd_chk("ovf_stat_cleared", ADDR_STATUS, 32'h0);

      // wrap on the same edge as W1C: set wins
      wr(ADDR_CNT_BASE + 4'd3, 32'hFFFF_FFFF);
      collide(4'b1000, ADDR_STATUS, 32'h8);
      rd_chk("setwin_stat", ADDR_STATUS, 32'h8);
      rd_chk("setwin_c3", 4'd7, 32'h0);
      wr(ADDR_STATUS, 32'h8);

      // write beats increment, no overflow from the masked wrap
      wr(ADDR_CNT_BASE, 32'hFFFF_FFFF);
      collide(4'b0001, ADDR_CNT_BASE, 32'h100);
      rd_chk("wrinc_c0", 4'd4, 32'h100);
      rd_chk("wrinc_stat", ADDR_STATUS, 32'h0);

      // clear_all beats increment
      wr(ADDR_CNT_BASE + 4'd1, 32'd5);
      collide(4'b1111, ADDR_CTRL, 32'h5);
      for (int k = 0; k < 4; k++) rd_chk($sformatf("clr_c%0d", k), ADDR_CNT_BASE + 4'(k), 32'h0);
      rd_chk("clr_ctrl", ADDR_CTRL, 32'h1);

      // error read with held response, then reset in RESP
      wr(ADDR_CNT_BASE + 4'd2, 32'h55);
      wr(4'd3, 32'hFFFF_FFFF);
      rd_chk("badwr_c2", 4'd6, 32'h55);
      cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd3;
      tick();
      cfg_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("hold%0d_rvalid", i), 32'(cfg_rvalid), 32'h1);
         chk($sformatf("hold%0d_rdata", i), cfg_rdata, 32'h0);
         chk($sformatf("hold%0d_err", i), 32'(cfg_err), 32'h1);
         chk($sformatf("hold%0d_ready", i), 32'(cfg_ready), 32'h0);
         tick();
      end
      rst_i = 1'b1;
      tick();
      chk("rstresp_rvalid", 32'(cfg_rvalid), 32'h0);
      chk("rstresp_ready", 32'(cfg_ready), 32'h1);
      rst_i = 1'b0;
      tick();
      rd_chk("rstresp_ctrl", ADDR_CTRL, 32'h0);
      rd_chk("rstresp_c2", 4'd6, 32'h0);

      // freeze
      wr(ADDR_CTRL, 32'h3);
      wr(ADDR_CNT_BASE + 4'd2, 32'd7);
      ev(4'b0100, PRIV_M, 16'h0, 1'b0, 10);
      settle();
      rd_chk("frz_c2", 4'd6, 32'd7);
      wr(ADDR_CTRL, 32'h1);
      // read accepted one edge after registration still sees the old value
      e_id = 4'b0100; e_info = {PRIV_M, 16'h0};
      tick();
      e_id = '0;
      rd_chk("lat_early", 4'd6, 32'd7);
      rd_chk("lat_after", 4'd6, 32'd8);
      // read accepted two edges after registration sees the increment
      e_id = 4'b0100;
      tick();
      e_id = '0;
      tick();
      rd_chk("lat_two", 4'd6, 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
